ped_request_conditioner: RTL and testbench

Upstream stage of the intersection traffic-light controller. It takes the raw, asynchronous, bouncy pedestrian push-button and produces a clean, held `ped_req` level that drives the controller's `pedestrian_btn` input. It holds the request until the controller shows WALK, then applies a post-walk lockout so one crossing is not immediately re-requested. It also counts button presses for diagnostics.

---
 rtl/ped_pkg.sv | 19 +
 rtl/btn_debouncer.sv | 67 ++++++
 rtl/ped_request_conditioner.sv | 90 +++++++++
 tb/tb_ped_request_conditioner.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/ped_pkg.sv
// Shared types and default constants for the pedestrian request path.
package ped_pkg;

    // Request FSM encoding; the controller-facing outputs are decoded from it.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        PENDING = 2'b01,
        SERVING = 2'b10,
        LOCKOUT = 2'b11
    } ped_state_t;

    // Stable cycles before the debounced button level may change.
    localparam int DEF_DB_CYCLES      = 16;
    // Cycles after a WALK during which no new request is raised.
    localparam int DEF_LOCKOUT_CYCLES = 64;
    // Width of the diagnostic press counter.
    localparam int DEF_CNT_W          = 8;

endpackage : ped_pkg

// File: rtl/btn_debouncer.sv
// Reusable button front end: two-flop synchronizer, stability-count
// debouncer and rising-edge press detector.
module btn_debouncer
    import ped_pkg::*;
#(
    parameter int DB_CYCLES = DEF_DB_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_clean,
    output logic press
);

    localparam int                DB_W    = $clog2(DB_CYCLES + 1);
    localparam logic [DB_W-1:0]   DB_LAST = DB_W'(DB_CYCLES - 1);

    logic            btn_meta;
    logic            btn_sync;
    logic [DB_W-1:0] db_cnt;
    logic            btn_clean_d;

    // Bring the asynchronous button into the clk domain.
    // NOTE: btn_meta may go metastable; nothing but the second flop may read it.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_meta <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments let both flops sample the old value,
            // forming a real two-stage shift instead of a single wire.
            btn_meta <= btn_raw;
            btn_sync <= btn_meta;
        end
    end

    // Count consecutive cycles where the synchronized level disagrees with the
    // clean level; accept the new level only after DB_CYCLES of them.
    always_ff @(posedge clk) begin
        if (rst) begin
            db_cnt    <= '0;
            btn_clean <= 1'b0;
        end else if (btn_sync != btn_clean) begin
            if (db_cnt == DB_LAST) begin
                btn_clean <= btn_sync;
                db_cnt    <= '0;
            end else begin
                db_cnt    <= db_cnt + 1'b1;
            end
        end else begin
            db_cnt <= '0;
        end
    end

    // Delayed copy of the clean level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            btn_clean_d <= 1'b0;
        end else begin
            btn_clean_d <= btn_clean;
        end
    end

    // One-cycle pulse on each debounced press; releases produce nothing.
    assign press = btn_clean & ~btn_clean_d;

endmodule : btn_debouncer

// File: rtl/ped_request_conditioner.sv
// Turns a raw pedestrian button into a held request for the intersection
// controller, with a post-WALK lockout and a saturating press counter.
module ped_request_conditioner
    import ped_pkg::*;
#(
    parameter int DB_CYCLES      = DEF_DB_CYCLES,
    parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES,
    parameter int CNT_W          = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             btn_raw,
    input  logic             walk_active,
    output logic             ped_req,
    output logic             btn_clean,
    output logic             lockout,
    output logic [CNT_W-1:0] press_count
);

    localparam int              LK_W      = $clog2(LOCKOUT_CYCLES + 1);
    localparam logic [LK_W-1:0] LK_RELOAD = LK_W'(LOCKOUT_CYCLES - 1);

    logic            press;
    ped_state_t      state;
    logic [LK_W-1:0] lk_cnt;
    logic            deferred;

    btn_debouncer #(
        .DB_CYCLES (DB_CYCLES)
    ) u_debouncer (
        .clk       (clk),
        .rst       (rst),
        .btn_raw   (btn_raw),
        .btn_clean (btn_clean),
        .press     (press)
    );

    // Request FSM with its lockout timer and deferred-press flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            lk_cnt   <= '0;
            deferred <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // A WALK without a press here belongs to someone else.
                    if (press) state <= PENDING;
                end
                PENDING: begin
                    // Extra presses merge into the one outstanding request.
                    if (walk_active) state <= SERVING;
                end
                SERVING: begin
                    if (!walk_active) begin
                        state  <= LOCKOUT;
                        lk_cnt <= LK_RELOAD;
                    end
                end
                LOCKOUT: begin
                    if (lk_cnt == '0) begin
                        // A press on the expiry edge still counts as deferred.
                        state    <= (deferred || press) ? PENDING : IDLE;
                        deferred <= 1'b0;
                    end else begin
                        lk_cnt <= lk_cnt - 1'b1;
                        if (press) deferred <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    deferred <= 1'b0;
                end
            endcase
        end
    end

    // Diagnostic count of debounced presses, held at full scale.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_count <= '0;
        end else if (press && (press_count != {CNT_W{1'b1}})) begin
            press_count <= press_count + 1'b1;
        end
    end

    assign ped_req = (state == PENDING);
    assign lockout = (state == LOCKOUT);

endmodule : ped_request_conditioner

// File: tb/tb_ped_request_conditioner.sv
// Directed bench for ped_request_conditioner. Inputs change 1 ns after each
// rising edge and outputs are sampled at the same point.
module tb_ped_request_conditioner;

    logic       clk;
    logic       rst;
    logic       btn_raw;
    logic       btn_raw_b;
    logic       walk_active;

    logic       ped_req_a, btn_clean_a, lockout_a;
    logic [7:0] press_count_a;
    logic       ped_req_b, btn_clean_b, lockout_b;
    logic [1:0] press_count_b;

    int checks = 0;
    int errors = 0;

    ped_request_conditioner #(
        .DB_CYCLES      (16),
        .LOCKOUT_CYCLES (64),
        .CNT_W          (8)
    ) dut_a (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .walk_active (walk_active),
        .ped_req     (ped_req_a),
        .btn_clean   (btn_clean_a),
        .lockout     (lockout_a),
        .press_count (press_count_a)
    );

    // Narrow-counter instance for the saturation check.
    ped_request_conditioner #(
        .DB_CYCLES      (16),
        .LOCKOUT_CYCLES (64),
        .CNT_W          (2)
    ) dut_b (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw_b),
        .walk_active (walk_active),
        .ped_req     (ped_req_b),
        .btn_clean   (btn_clean_b),
        .lockout     (lockout_b),
        .press_count (press_count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    int  hi_w [3] = '{3, 5, 15};
    bit  seen;
    bit  drop_a;
    bit  drop_b;
    int  lk_cycles;
    int  exp_b;

    initial begin
        rst         = 1'b1;
        btn_raw     = 1'b0;
        btn_raw_b   = 1'b0;
        walk_active = 1'b0;

        // Reset state.
        step(3);
        check("rst_ped_req",  32'(ped_req_a),     0);
        check("rst_clean",    32'(btn_clean_a),   0);
        check("rst_lockout",  32'(lockout_a),     0);
        check("rst_count",    32'(press_count_a), 0);
        rst = 1'b0;

        // Bounce rejection: high pulses of 3, 5 and 15 cycles.
        seen = 1'b0;
        for (int k = 0; k < 3; k++) begin
            btn_raw = 1'b1;
            for (int c = 0; c < hi_w[k]; c++) begin
                step(1);
                if (btn_clean_a || ped_req_a) seen = 1'b1;
            end
            btn_raw = 1'b0;
            for (int c = 0; c < hi_w[k] + 5; c++) begin
                step(1);
                if (btn_clean_a || ped_req_a) seen = 1'b1;
            end
        end
        step(5);
        check("bounce_no_change", 32'(seen),          0);
        check("bounce_count",     32'(press_count_a), 0);

        // Clean press: the next edge is edge 0.
        btn_raw = 1'b1;
        step(17);
        check("press_clean_e16", 32'(btn_clean_a), 0);
        step(1);
        check("press_clean_e17", 32'(btn_clean_a), 1);
        check("press_req_e17",   32'(ped_req_a),   0);
        step(1);
        check("press_req_e18",   32'(ped_req_a),     1);
        check("press_count_1",   32'(press_count_a), 1);

        // Release: no press on the falling edge, request held.
        btn_raw = 1'b0;
        step(20);
        check("release_clean", 32'(btn_clean_a),   0);
        check("release_req",   32'(ped_req_a),     1);
        check("release_count", 32'(press_count_a), 1);

        // Service handshake: walk for 4 cycles then lockout.
        walk_active = 1'b1;
        step(1);
        check("serve_req_drop", 32'(ped_req_a), 0);
        check("serve_no_lock",  32'(lockout_a), 0);
        step(3);
        walk_active = 1'b0;
        lk_cycles = 0;
        seen      = 1'b0;
        for (int i = 0; i < 200; i++) begin
            step(1);
            if (lockout_a) lk_cycles++;
            if (ped_req_a) seen = 1'b1;
            if (!lockout_a && lk_cycles > 0) break;
        end
        check("lockout_len",      32'(lk_cycles), 64);
        check("lockout_no_req",   32'(seen),      0);
        check("idle_after_lock",  32'(ped_req_a), 0);
        check("idle_lock_low",    32'(lockout_a), 0);

        // New request to set up the deferred-press case.
        btn_raw = 1'b1;
        step(19);
        check("rereq_req",   32'(ped_req_a),     1);
        check("rereq_count", 32'(press_count_a), 2);
        btn_raw = 1'b0;
        step(20);

        // Deferred press: button edge 0 is one edge after walk starts, lockout
        // entry is relative edge 8, press lands at lockout entry + 10.
        walk_active = 1'b1;
        step(1);
        btn_raw = 1'b1;
        step(8);
        walk_active = 1'b0;
        step(1);
        check("defer_lock_entry", 32'(lockout_a), 1);
        step(9);
        check("defer_count_pre",  32'(press_count_a), 2);
        step(1);
        check("defer_count_post", 32'(press_count_a), 3);
        check("defer_req_held",   32'(ped_req_a),     0);
        step(53);
        check("defer_lock_last",  32'(lockout_a), 1);
        check("defer_req_last",   32'(ped_req_a), 0);
        step(1);
        check("defer_lock_end",   32'(lockout_a), 0);
        check("defer_req_rise",   32'(ped_req_a), 1);

        // Saturation and merging: dut_b enters PENDING on the first of seven
        // presses, then absorbs six more while walk_active stays low.
        btn_raw = 1'b0;
        step(20);
        drop_a = 1'b0;
        drop_b = 1'b0;
        for (int k = 0; k < 7; k++) begin
            btn_raw   = 1'b1;
            btn_raw_b = 1'b1;
            for (int c = 0; c < 40; c++) begin
                if (c == 20) begin
                    btn_raw   = 1'b0;
                    btn_raw_b = 1'b0;
                end
                step(1);
                if (!ped_req_a) drop_a = 1'b1;
                if (k > 0 && !ped_req_b) drop_b = 1'b1;
            end
            exp_b = (k + 1 > 3) ? 3 : k + 1;
            check($sformatf("sat_count_%0d", k), 32'(press_count_b), 32'(exp_b));
        end
        check("merge_req_a",   32'(drop_a),        0);
        check("merge_req_b",   32'(drop_b),        0);
        check("merge_count_a", 32'(press_count_a), 10);

        // Reset mid-request with the button held.
        btn_raw   = 1'b1;
        btn_raw_b = 1'b1;
        step(20);
        check("pre_rst_count", 32'(press_count_a), 11);
        rst = 1'b1;
        step(1);
        check("midrst_req",     32'(ped_req_a),     0);
        check("midrst_clean",   32'(btn_clean_a),   0);
        check("midrst_lockout", 32'(lockout_a),     0);
        check("midrst_count",   32'(press_count_a), 0);
        check("midrst_req_b",   32'(ped_req_b),     0);
        rst = 1'b0;
        step(18);
        check("postrst_req_e17",   32'(ped_req_a),   0);
        check("postrst_clean_e17", 32'(btn_clean_a), 1);
        step(1);
        check("postrst_req_e18",   32'(ped_req_a),     1);
        check("postrst_count",     32'(press_count_a), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ped_request_conditioner
